// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave memory port arbiter (I-cache = master 0, D-cache = master 1).
// Grant is held across consecutive beats; an optional beat cap lets a waiting master preempt.
module mem_bus_arbiter #(
  parameter string TAG       = "mem_arb",
  parameter int    MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_dataOut,
  input  logic        m0_re,
  input  logic        m0_we,
  output logic [31:0] m0_dataIn,
  output logic        m0_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_dataOut,
  input  logic        m1_re,
  input  logic        m1_we,
  output logic [31:0] m1_dataIn,
  output logic        m1_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataOut,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_dataIn,
  input  logic        mem_ready
);

  // Counter is at least one bit wide so the uncapped build still elaborates.
  localparam int CntW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CntW-1:0] CntMax = (MAX_BURST > 0) ? CntW'(MAX_BURST - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } stateT;

  stateT           state, nextState;
  logic            lastOwner, nextLastOwner;
  logic [CntW-1:0] beatCnt, nextBeatCnt;
  logic            req0, req1;
  logic            capHit;

  assign req0 = m0_re | m0_we;
  assign req1 = m1_re | m1_we;

  // Cap only fires on a completed beat, so a burst is never cut mid-beat.
  assign capHit = (MAX_BURST != 0) && mem_ready && (beatCnt == CntMax);

  assign m0_dataIn = mem_dataIn;
  assign m1_dataIn = mem_dataIn;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= S_IDLE;
      lastOwner <= 1'b1;
      beatCnt   <= '0;
    end else begin
      state     <= nextState;
      lastOwner <= nextLastOwner;
      beatCnt   <= nextBeatCnt;
    end
  end

  always_comb begin
    nextState     = state;
    nextLastOwner = lastOwner;
    nextBeatCnt   = beatCnt;
    mem_addr      = '0;
    mem_dataOut   = '0;
    mem_re        = 1'b0;
    mem_we        = 1'b0;
    m0_ready      = 1'b0;
    m1_ready      = 1'b0;

    case (state)
      S_IDLE: begin
        if (req0 && req1) begin
          nextState = lastOwner ? S_OWN0 : S_OWN1;
        end else if (req0) begin
          nextState = S_OWN0;
        end else if (req1) begin
          nextState = S_OWN1;
        end
      end

      S_OWN0: begin
        mem_addr    = m0_addr;
        mem_dataOut = m0_dataOut;
        mem_re      = m0_re;
        mem_we      = m0_we;
        m0_ready    = mem_ready;
        if (!req0) begin
          nextState     = S_IDLE;
          nextLastOwner = 1'b0;
          nextBeatCnt   = '0;
        end else if (capHit && req1) begin
          nextState     = S_OWN1;
          nextLastOwner = 1'b0;
          nextBeatCnt   = '0;
        end else if (mem_ready && (beatCnt != CntMax)) begin
          nextBeatCnt = beatCnt + CntW'(1);
        end
      end

      S_OWN1: begin
        mem_addr    = m1_addr;
        mem_dataOut = m1_dataOut;
        mem_re      = m1_re;
        mem_we      = m1_we;
        m1_ready    = mem_ready;
        if (!req1) begin
          nextState     = S_IDLE;
          nextLastOwner = 1'b1;
          nextBeatCnt   = '0;
        end else if (capHit && req0) begin
          nextState     = S_OWN0;
          nextLastOwner = 1'b1;
          nextBeatCnt   = '0;
        end else if (mem_ready && (beatCnt != CntMax)) begin
          nextBeatCnt = beatCnt + CntW'(1);
        end
      end

      default: nextState = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Table-driven bench for mem_bus_arbiter: one instance with a 4-beat cap, one uncapped.
// Each row drives one cycle; its expectation goes through a scoreboard queue.
module tb_mem_bus_arbiter;

  localparam logic [31:0] M0Addr = 32'h0000_0100;
  localparam logic [31:0] M1Addr = 32'h0000_0200;
  localparam logic [31:0] M0Data = 32'hA0A0_1234;
  localparam logic [31:0] M1Data = 32'hB1B1_5678;

  logic        clk;
  logic        res_n;
  logic [31:0] m0_addr, m0_dataOut, m1_addr, m1_dataOut, mem_dataIn;
  logic        m0_re, m0_we, m1_re, m1_we, mem_ready;

  logic [31:0] capM0DataIn, capM1DataIn, capMemAddr, capMemDataOut;
  logic        capM0Ready, capM1Ready, capMemRe, capMemWe;
  logic [31:0] ncM0DataIn, ncM1DataIn, ncMemAddr, ncMemDataOut;
  logic        ncM0Ready, ncM1Ready, ncMemRe, ncMemWe;

  mem_bus_arbiter #(.MAX_BURST(4)) dutCap (
    .clk(clk), .res_n(res_n),
    .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_re(m0_re), .m0_we(m0_we),
    .m0_dataIn(capM0DataIn), .m0_ready(capM0Ready),
    .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_re(m1_re), .m1_we(m1_we),
    .m1_dataIn(capM1DataIn), .m1_ready(capM1Ready),
    .mem_addr(capMemAddr), .mem_dataOut(capMemDataOut), .mem_re(capMemRe), .mem_we(capMemWe),
    .mem_dataIn(mem_dataIn), .mem_ready(mem_ready)
  );

  mem_bus_arbiter #(.MAX_BURST(0)) dutNoCap (
    .clk(clk), .res_n(res_n),
    .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_re(m0_re), .m0_we(m0_we),
    .m0_dataIn(ncM0DataIn), .m0_ready(ncM0Ready),
    .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_re(m1_re), .m1_we(m1_we),
    .m1_dataIn(ncM1DataIn), .m1_ready(ncM1Ready),
    .mem_addr(ncMemAddr), .mem_dataOut(ncMemDataOut), .mem_re(ncMemRe), .mem_we(ncMemWe),
    .mem_dataIn(mem_dataIn), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // req = {m0_re, m0_we, m1_re, m1_we, mem_ready}; own: 0 idle, 1 master 0, 2 master 1
  // exp = {mem_re, mem_we, m0_ready, m1_ready}; sel picks the capped (0) or uncapped (1) DUT
  typedef struct {
    string       name;
    bit          sel;
    bit          rstN;
    bit [4:0]    req;
    int          own;
    bit [3:0]    exp;
    logic [31:0] memIn;
  } vecT;

  typedef struct {
    string       name;
    bit          sel;
    logic [135:0] expBits;
  } expT;

  vecT vecQ[$];
  expT expQ[$];
  int  testsRun = 0;
  int  testsFailed = 0;

  task automatic addRow(input string nm, input bit sel, input bit rstN, input bit [4:0] req,
                        input int own, input bit [3:0] exp);
    vecT v;
    v.name  = nm;
    v.sel   = sel;
    v.rstN  = rstN;
    v.req   = req;
    v.own   = own;
    v.exp   = exp;
    v.memIn = $urandom;
    vecQ.push_back(v);
  endtask

  task automatic applyStimulus(input vecT v);
    expT e;
    logic [31:0] eAddr, eData;
    res_n      = v.rstN;
    {m0_re, m0_we, m1_re, m1_we, mem_ready} = v.req;
    mem_dataIn = v.memIn;
    eAddr = (v.own == 1) ? M0Addr : (v.own == 2) ? M1Addr : 32'h0;
    eData = (v.own == 1) ? M0Data : (v.own == 2) ? M1Data : 32'h0;
    e.name    = v.name;
    e.sel     = v.sel;
    e.expBits = {4'b0, v.exp, eAddr, eData, v.memIn, v.memIn};
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    expT e;
    logic [135:0] act;
    if (expQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard: queue empty, got nothing, required one entry");
      return;
    end
    e = expQ.pop_front();
    if (e.sel)
      act = {4'b0, ncMemRe, ncMemWe, ncM0Ready, ncM1Ready, ncMemAddr, ncMemDataOut,
             ncM0DataIn, ncM1DataIn};
    else
      act = {4'b0, capMemRe, capMemWe, capM0Ready, capM1Ready, capMemAddr, capMemDataOut,
             capM0DataIn, capM1DataIn};
    testsRun++;
    if (act !== e.expBits) begin
      testsFailed++;
      $display("[TB] FAIL %s: got {re,we,rdy0,rdy1}=%b addr=%h wdata=%h din=%h/%h, required %b addr=%h wdata=%h din=%h/%h",
               e.name, act[131:128], act[127:96], act[95:64], act[63:32], act[31:0],
               e.expBits[131:128], e.expBits[127:96], e.expBits[95:64], e.expBits[63:32],
               e.expBits[31:0]);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res_n      = 1'b0;
    m0_addr    = M0Addr;
    m0_dataOut = M0Data;
    m1_addr    = M1Addr;
    m1_dataOut = M1Data;
    {m0_re, m0_we, m1_re, m1_we, mem_ready} = 5'b0;
    mem_dataIn = '0;

    // Reset holds everything quiet even with a request pending; then a 3-beat m0 read.
    addRow("rst",      0, 0, 5'b10001, 0, 4'b0000);
    addRow("A.bubble", 0, 1, 5'b10001, 0, 4'b0000);
    addRow("A.beat1",  0, 1, 5'b10001, 1, 4'b1010);
    addRow("A.beat2",  0, 1, 5'b10001, 1, 4'b1010);
    addRow("A.beat3",  0, 1, 5'b10001, 1, 4'b1010);
    addRow("A.drop",   0, 1, 5'b00000, 1, 4'b0000);
    addRow("A.idle",   0, 1, 5'b00000, 0, 4'b0000);

    // Simultaneous requests after reset: m0 first, one bubble, then m1 write.
    addRow("B.rst",    0, 0, 5'b00000, 0, 4'b0000);
    addRow("B.bubble", 0, 1, 5'b10011, 0, 4'b0000);
    addRow("B.m0b1",   0, 1, 5'b10011, 1, 4'b1010);
    addRow("B.m0b2",   0, 1, 5'b10011, 1, 4'b1010);
    addRow("B.m0drop", 0, 1, 5'b00010, 1, 4'b0000);
    addRow("B.idle",   0, 1, 5'b00010, 0, 4'b0000);
    addRow("B.m1wr",   0, 1, 5'b00011, 2, 4'b0101);
    addRow("B.m1drop", 0, 1, 5'b00000, 2, 4'b0000);
    addRow("B.idle2",  0, 1, 5'b00000, 0, 4'b0000);

    // Cap of 4: m0 is preempted on its 4th beat, m1 stalls 5 cycles then is preempted back.
    addRow("C.bubble", 0, 1, 5'b10101, 0, 4'b0000);
    for (int i = 1; i <= 4; i++)
      addRow($sformatf("C.m0b%0d", i), 0, 1, 5'b10101, 1, 4'b1010);
    addRow("C.m1b1",   0, 1, 5'b10101, 2, 4'b1001);
    for (int i = 1; i <= 5; i++)
      addRow($sformatf("C.stall%0d", i), 0, 1, 5'b10100, 2, 4'b1000);
    for (int i = 2; i <= 4; i++)
      addRow($sformatf("C.m1b%0d", i), 0, 1, 5'b10101, 2, 4'b1001);
    addRow("C.m0back", 0, 1, 5'b10100, 1, 4'b1000);
    addRow("C.m0drop", 0, 1, 5'b00000, 1, 4'b0000);
    addRow("C.idle",   0, 1, 5'b00000, 0, 4'b0000);

    // Reset lands while m1 is writing: strobe drops at once, tie afterwards goes to m0.
    addRow("D.bubble", 0, 1, 5'b00010, 0, 4'b0000);
    addRow("D.m1we",   0, 1, 5'b00010, 2, 4'b0100);
    addRow("D.rstMid", 0, 0, 5'b00011, 0, 4'b0000);
    addRow("D.bubble2",0, 1, 5'b10011, 0, 4'b0000);
    addRow("D.tieM0",  0, 1, 5'b10011, 1, 4'b1010);
    addRow("D.m0drop", 0, 1, 5'b00010, 1, 4'b0000);
    addRow("D.idle",   0, 1, 5'b00010, 0, 4'b0000);
    addRow("D.m1wr",   0, 1, 5'b00011, 2, 4'b0101);
    addRow("D.m1drop", 0, 1, 5'b00000, 2, 4'b0000);
    addRow("D.idle2",  0, 1, 5'b00000, 0, 4'b0000);

    // Uncapped instance: m1 keeps the port for 40 beats despite m0 waiting.
    addRow("E.rst",    1, 0, 5'b00000, 0, 4'b0000);
    addRow("E.bubble", 1, 1, 5'b00010, 0, 4'b0000);
    for (int i = 1; i <= 40; i++)
      addRow($sformatf("E.m1b%0d", i), 1, 1, 5'b10011, 2, 4'b0101);
    addRow("E.m1drop", 1, 1, 5'b10000, 2, 4'b0000);
    addRow("E.idle",   1, 1, 5'b10000, 0, 4'b0000);
    addRow("E.m0b1",   1, 1, 5'b10001, 1, 4'b1010);
    addRow("E.m0drop", 1, 1, 5'b00000, 1, 4'b0000);
    addRow("E.idle2",  1, 1, 5'b00000, 0, 4'b0000);

    foreach (vecQ[i]) begin
      @(posedge clk);
      #1;
      applyStimulus(vecQ[i]);
      @(negedge clk);
      checkOutput();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
